alert_response_ctrl: RTL and testbench
======================================

// Module: alert_response_ctrl
// PURPOSE
//   Consumer of anomaly_detector alerts. Debounces alert episodes, runs the
//   trading circuit-breaker FSM (NORMAL/THROTTLE/HALT/COOLDOWN) whose halt/throttle
//   outputs gate the order book, and queues one timestamped event record per
//   qualified episode into a small FIFO drained over a valid/ready interface.
// PARAMETERS
//   DEBOUNCE       2   consecutive cycles an alert (same type) must persist; >=1
//   THROTTLE_PRIO  4   min alert_priority that forces THROTTLE
//   HALT_PRIO      7   min alert_priority that forces HALT (7 = flash crash)
//   COOLDOWN_CYC   64  quiet cycles (alert_any=0) required to leave COOLDOWN
//   FIFO_DEPTH     4   event records buffered (power of 2)
// PORTS
//   clk            in   1   clock
//   rst_n          in   1   async active-low reset
//   alert_any      in   1   any detector active
//   alert_priority in   3   priority of highest active alert
//   alert_type     in   3   type of highest active alert
//   alert_bitmap   in   8   all detector flags
//   clear_req      in   1   operator acknowledge, 1-cycle pulse
//   halt           out  1   1 = order book must reject all orders
//   throttle       out  1   1 = order book rate-limited
//   state          out  2   0 NORMAL, 1 THROTTLE, 2 HALT, 3 COOLDOWN
//   sticky_bitmap  out  8   OR of alert_bitmap since last accepted clear
//   evt_valid      out  1   FIFO non-empty
//   evt_ready      in   1   consumer accepts head record
//   evt_data       out  16  {type[2:0], priority[2:0], timestamp[9:0]} of head
//   evt_dropped    out  8   events lost to full FIFO, saturates at 255
// BEHAVIOUR
//   Reset: state NORMAL; halt, throttle, evt_valid, sticky, evt_dropped, 10-bit
//     timestamp, run counter all 0; evt_data 0; FIFO empty.
//   Timestamp: free-running 10-bit counter, +1 every cycle, wraps 1023->0.
//   Run counter: alert_any=0 -> 0; alert_any=1 and type equals last sampled
//     type and run>0 -> run+1 (saturating at DEBOUNCE); else -> 1.
//   Qualify (comb): run_next==DEBOUNCE && run!=DEBOUNCE. One per episode; type
//     change starts new episode. DEBOUNCE=1 qualifies on first sampled cycle.
//   On qualifying edge: push {alert_type, alert_priority, timestamp} (pre-inc).
//   FSM, evaluated on every edge (q = qualify, p = alert_priority):
//     NORMAL:   q&&p>=HALT_PRIO -> HALT; q&&p>=THROTTLE_PRIO -> THROTTLE.
//     THROTTLE: q&&p>=HALT_PRIO -> HALT; alert_any=0 -> COOLDOWN (count=0).
//     HALT:     clear_req && alert_any=0 -> COOLDOWN (count=0); clear_req
//               with alert_any=1 ignored entirely (sticky also kept).
//     COOLDOWN: q&&p>=HALT_PRIO -> HALT; q&&p>=THROTTLE_PRIO -> THROTTLE;
//               alert_any=1 -> count=0; else count+1; count==COOLDOWN_CYC-1
//               with alert_any=0 -> NORMAL.
//   Outputs registered from state: halt=(HALT); throttle=(THROTTLE|COOLDOWN).
//     Latency: halt rises on the same edge that qualifies (DEBOUNCE edges after
//     first alert sample).
//   Sticky: sticky <= alert_bitmap | (accepted_clear ? 0 : sticky). Accepted
//     clear = clear_req && alert_any=0 (any state); same-cycle bits survive.
//   FIFO: first-word fall-through; pop on evt_valid&&evt_ready. Push+pop same
//     cycle when full: both occur, no drop. Push when full without pop: record
//     discarded, evt_dropped+1 (sat). evt_data holds head; 0 when empty.
//   Reset asserted mid-operation: immediate return to reset values, FIFO flushed.
// TESTING
//   1 Reset mid-HALT with 3 queued events -> all outputs 0, state=0, evt_valid=0.
//   2 alert_any=1,prio=7,type=7 for 5 cycles from ts=10 -> halt=1 after 2nd edge,
//     exactly one record 0xFC0B ({7,7,11}); no further records while held.
//   3 alert_any=1 prio=5 for 1 cycle only -> no record, state stays NORMAL.
//   4 prio=4 for 3 cycles then alert_any=0 -> THROTTLE, COOLDOWN, throttle=1 for
//     64 quiet cycles then NORMAL; alert at quiet cycle 30 restarts the count.
//   5 In HALT: clear_req with alert_any=1 -> no change; with alert_any=0 ->
//     COOLDOWN, halt=0, throttle=1, sticky_bitmap=0.
//   6 evt_ready=0, 6 qualified episodes -> 4 stored, evt_dropped=2; evt_ready=1
//     drains the first 4 in order; full+push+pop same cycle -> no drop.

Source files
------------

// File: rtl/alert_response_ctrl_if.sv
// Alert-response bundle: detector alerts and operator clear in, breaker and event stream out.
// Latency: none, signal grouping only.
// Backpressure: evt_valid/evt_ready handshake on the event record stream.
interface alert_response_ctrl_if;
   logic        alert_any;
   logic [2:0]  alert_priority;
   logic [2:0]  alert_type;
   logic [7:0]  alert_bitmap;
   logic        clear_req;
   logic        halt;
   logic        throttle;
   logic [1:0]  state;
   logic [7:0]  sticky_bitmap;
   logic        evt_valid;
   logic        evt_ready;
   logic [15:0] evt_data;
   logic [7:0]  evt_dropped;

   // Alert source / event consumer side
   modport master (
      output alert_any, alert_priority, alert_type, alert_bitmap, clear_req, evt_ready,
      input  halt, throttle, state, sticky_bitmap, evt_valid, evt_data, evt_dropped
   );

   // Controller side
   modport slave (
      input  alert_any, alert_priority, alert_type, alert_bitmap, clear_req, evt_ready,
      output halt, throttle, state, sticky_bitmap, evt_valid, evt_data, evt_dropped
   );
endinterface

// File: rtl/alert_response_ctrl.sv
// Debounces alert episodes, runs the NORMAL/THROTTLE/HALT/COOLDOWN breaker, queues event records.
// Latency: halt/throttle update on the qualifying edge; records visible (FWFT) the cycle after push.
// Backpressure: evt_ready gates pops; a push into a full FIFO without a same-cycle pop is dropped and counted.
module alert_response_ctrl #(
   parameter int DEBOUNCE      = 2,
   parameter int THROTTLE_PRIO = 4,
   parameter int HALT_PRIO     = 7,
   parameter int COOLDOWN_CYC  = 64,
   parameter int FIFO_DEPTH    = 4    // power of 2, >= 2
) (
   input  logic clk,
   input  logic rst_n,
   alert_response_ctrl_if.slave io
);
   localparam int RW = $clog2(DEBOUNCE + 1);
   localparam int CW = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int NW = AW + 1;

   localparam logic [RW-1:0] RUN_MAX   = RW'(DEBOUNCE);
   localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN_CYC - 1);
   localparam logic [NW-1:0] FIFO_FULL = NW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_NORMAL   = 2'd0,
      ST_THROTTLE = 2'd1,
      ST_HALT     = 2'd2,
      ST_COOLDOWN = 2'd3
   } state_e;

   logic [9:0]    ts_q;
   logic [RW-1:0] run_q, run_d;
   logic [2:0]    last_type_q;
   logic          qualify;
   logic          want_halt, want_thr;

   state_e        state_q, state_d;
   logic [CW-1:0] cool_q, cool_d;
   logic          halt_q, halt_d;
   logic          throttle_q, throttle_d;

   logic [7:0]    sticky_q;
   logic          accepted_clear;

   logic [15:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [NW-1:0] cnt_q;
   logic [7:0]    drop_q;
   logic          fifo_empty, fifo_full, pop, push, drop;

   // Run length of the current same-type alert streak, saturating at DEBOUNCE
   always_comb begin
      run_d = '0;
      if (io.alert_any) begin
         if ((io.alert_type == last_type_q) && (run_q != '0)) begin
            run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
         end else begin
            run_d = RW'(1);
         end
      end
   end

   // An episode qualifies exactly once: on the edge its run first reaches DEBOUNCE
   assign qualify   = (run_d == RUN_MAX) && (run_q != RUN_MAX);
   assign want_halt = qualify && (io.alert_priority >= 3'(HALT_PRIO));
   assign want_thr  = qualify && (io.alert_priority >= 3'(THROTTLE_PRIO));

   // Free-running timestamp and debounce tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_q        <= '0;
         run_q       <= '0;
         last_type_q <= '0;
      end else begin
         ts_q        <= ts_q + 10'd1;
         run_q       <= run_d;
         last_type_q <= io.alert_type;
      end
   end

   // Breaker state register; halt/throttle are registered decodes of the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_NORMAL;
         cool_q     <= '0;
         halt_q     <= 1'b0;
         throttle_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cool_q     <= cool_d;
         halt_q     <= halt_d;
         throttle_q <= throttle_d;
      end
   end

   // Breaker next-state: escalate on qualified episodes, relax only through COOLDOWN
   always_comb begin
      state_d = state_q;
      cool_d  = cool_q;
      case (state_q)
         ST_NORMAL: begin
            if (want_halt)     state_d = ST_HALT;
            else if (want_thr) state_d = ST_THROTTLE;
         end
         ST_THROTTLE: begin
            if (want_halt) begin
               state_d = ST_HALT;
            end else if (!io.alert_any) begin
               state_d = ST_COOLDOWN;
               cool_d  = '0;
            end
         end
         ST_HALT: begin
            // Only an operator clear during a quiet cycle releases a halt
            if (io.clear_req && !io.alert_any) begin
               state_d = ST_COOLDOWN;
               cool_d  = '0;
            end
         end
         ST_COOLDOWN: begin
            if (want_halt) begin
               state_d = ST_HALT;
            end else if (want_thr) begin
               state_d = ST_THROTTLE;
            end else if (io.alert_any) begin
               cool_d = '0;
            end else if (cool_q == COOL_LAST) begin
               state_d = ST_NORMAL;
            end else begin
               cool_d = cool_q + 1'b1;
            end
         end
         default: state_d = ST_NORMAL;
      endcase
      halt_d     = (state_d == ST_HALT);
      throttle_d = (state_d == ST_THROTTLE) || (state_d == ST_COOLDOWN);
   end

   // Sticky alert flags; bits arriving in the clearing cycle survive the clear
   assign accepted_clear = io.clear_req && !io.alert_any;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sticky_q <= '0;
      else        sticky_q <= io.alert_bitmap | (accepted_clear ? 8'h00 : sticky_q);
   end

   // Event FIFO control: a pop frees the slot for a same-cycle push when full
   assign fifo_empty = (cnt_q == '0);
   assign fifo_full  = (cnt_q == FIFO_FULL);
   assign pop        = !fifo_empty && io.evt_ready;
   assign push       = qualify && (!fifo_full || pop);
   assign drop       = qualify && fifo_full && !pop;

   // FIFO pointers, occupancy and saturating drop counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         drop_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + 1'b1;
         if (pop)  rd_q <= rd_q + 1'b1;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
         if (drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
      end
   end

   // Record storage; contents are don't-care while the slot is unoccupied
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= {io.alert_type, io.alert_priority, ts_q};
   end

   assign io.halt          = halt_q;
   assign io.throttle      = throttle_q;
   assign io.state         = state_q;
   assign io.sticky_bitmap = sticky_q;
   assign io.evt_valid     = !fifo_empty;
   assign io.evt_data      = fifo_empty ? 16'h0000 : mem_q[rd_q];
   assign io.evt_dropped   = drop_q;
endmodule

// File: tb/tb_alert_response_ctrl.sv
// Bench for alert_response_ctrl: vector table, directed corner sequences, randomized run vs a reference model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: evt_ready driven by the bench to exercise full/drop/drain behaviour.
module tb_alert_response_ctrl;
   localparam int DEB = 2, TPRIO = 4, HPRIO = 7, COOL = 64, DEPTH = 4;
   localparam int S_NORMAL = 0, S_THR = 1, S_HALT = 2, S_COOL = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   alert_response_ctrl_if bus ();

   alert_response_ctrl #(
      .DEBOUNCE(DEB), .THROTTLE_PRIO(TPRIO), .HALT_PRIO(HPRIO),
      .COOLDOWN_CYC(COOL), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int          m_ts, m_run, m_last, m_state, m_quiet, m_drop;
   logic [7:0]  m_sticky;
   logic [15:0] m_fifo[$];

   typedef struct {
      logic a; logic [2:0] p; logic [2:0] t; logic [7:0] bm; logic clr; logic rdy;
      logic e_halt; logic e_thr; logic [1:0] e_st; logic [7:0] e_stk; logic e_vld; logic [15:0] e_dat;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(input logic a, input logic [2:0] p, input logic [2:0] t,
                               input logic [7:0] bm, input logic clr, input logic rdy,
                               input logic eh, input logic et, input logic [1:0] es,
                               input logic [7:0] estk, input logic ev, input logic [15:0] ed);
      vec_t v;
      v.a = a; v.p = p; v.t = t; v.bm = bm; v.clr = clr; v.rdy = rdy;
      v.e_halt = eh; v.e_thr = et; v.e_st = es; v.e_stk = estk; v.e_vld = ev; v.e_dat = ed;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic m_reset();
      m_ts = 0; m_run = 0; m_last = 0; m_state = S_NORMAL; m_quiet = 0; m_drop = 0;
      m_sticky = 8'h00;
      m_fifo.delete();
   endtask

   // One clock edge of the specified behaviour, using the inputs currently driven
   task automatic m_step();
      int run_n;
      bit q;
      int lvl;
      bit acc;
      bit pop;
      logic [15:0] rec;
      if (!bus.alert_any)                                          run_n = 0;
      else if (int'(bus.alert_type) == m_last && m_run > 0)        run_n = (m_run + 1 > DEB) ? DEB : m_run + 1;
      else                                                         run_n = 1;
      q   = (run_n == DEB) && (m_run != DEB);
      lvl = !q ? 0 : (int'(bus.alert_priority) >= HPRIO) ? 2 : (int'(bus.alert_priority) >= TPRIO) ? 1 : 0;
      acc = bus.clear_req && !bus.alert_any;
      rec = {bus.alert_type, bus.alert_priority, 10'(m_ts)};
      pop = (m_fifo.size() > 0) && bus.evt_ready;
      if (pop) void'(m_fifo.pop_front());
      if (q) begin
         if (m_fifo.size() < DEPTH) m_fifo.push_back(rec);
         else if (m_drop < 255)     m_drop++;
      end
      case (m_state)
         S_NORMAL: if (lvl == 2) m_state = S_HALT; else if (lvl == 1) m_state = S_THR;
         S_THR: begin
            if (lvl == 2) m_state = S_HALT;
            else if (!bus.alert_any) begin m_state = S_COOL; m_quiet = 0; end
         end
         S_HALT: if (acc) begin m_state = S_COOL; m_quiet = 0; end
         default: begin
            if (lvl == 2)               m_state = S_HALT;
            else if (lvl == 1)          m_state = S_THR;
            else if (bus.alert_any)     m_quiet = 0;
            else if (m_quiet == COOL-1) m_state = S_NORMAL;
            else                        m_quiet++;
         end
      endcase
      m_sticky = bus.alert_bitmap | (acc ? 8'h00 : m_sticky);
      m_ts     = (m_ts + 1) % 1024;
      m_run    = run_n;
      m_last   = int'(bus.alert_type);
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".halt"},    16'(bus.halt),          16'(m_state == S_HALT));
      chk({tag, ".thr"},     16'(bus.throttle),      16'(m_state == S_THR || m_state == S_COOL));
      chk({tag, ".state"},   16'(bus.state),         16'(m_state));
      chk({tag, ".sticky"},  16'(bus.sticky_bitmap), 16'(m_sticky));
      chk({tag, ".valid"},   16'(bus.evt_valid),     16'(m_fifo.size() > 0));
      chk({tag, ".data"},    bus.evt_data,           (m_fifo.size() > 0) ? m_fifo[0] : 16'h0000);
      chk({tag, ".dropped"}, 16'(bus.evt_dropped),   16'(m_drop));
   endtask

   task automatic set_in(input logic a, input logic [2:0] p, input logic [2:0] t,
                         input logic [7:0] bm, input logic clr, input logic rdy);
      bus.alert_any = a; bus.alert_priority = p; bus.alert_type = t;
      bus.alert_bitmap = bm; bus.clear_req = clr; bus.evt_ready = rdy;
   endtask

   task automatic step(input string tag);
      m_step();
      @(posedge clk);
      #1;
      check_model(tag);
   endtask

   // Asynchronous reset away from the clock edge, checked before the next edge
   task automatic do_reset(input string tag);
      #2;
      rst_n = 1'b0;
      set_in(0, 0, 0, 8'h00, 0, 0);
      m_reset();
      #1;
      chk({tag, ".halt"},    16'(bus.halt),          16'h0);
      chk({tag, ".thr"},     16'(bus.throttle),      16'h0);
      chk({tag, ".state"},   16'(bus.state),         16'h0);
      chk({tag, ".sticky"},  16'(bus.sticky_bitmap), 16'h0);
      chk({tag, ".valid"},   16'(bus.evt_valid),     16'h0);
      chk({tag, ".data"},    bus.evt_data,           16'h0);
      chk({tag, ".dropped"}, 16'(bus.evt_dropped),   16'h0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] exp_rec;
      int mode;

      // Vectors from reset: held flash crash from ts=10, pop, ignored and accepted clears
      for (int i = 0; i < 10; i++) tv.push_back(mk(0,0,0,8'h00,0,0, 0,0,2'd0,8'h00,0,16'h0000));
      tv.push_back(mk(1,7,7,8'h80,0,0, 0,0,2'd0,8'h80,0,16'h0000));
      for (int i = 0; i < 4; i++)  tv.push_back(mk(1,7,7,8'h80,0,0, 1,0,2'd2,8'h80,1,16'hFC0B));
      tv.push_back(mk(0,0,0,8'h00,0,0, 1,0,2'd2,8'h80,1,16'hFC0B));
      tv.push_back(mk(0,0,0,8'h00,0,1, 1,0,2'd2,8'h80,0,16'h0000));
      tv.push_back(mk(1,5,2,8'h04,1,0, 1,0,2'd2,8'h84,0,16'h0000));
      tv.push_back(mk(0,0,0,8'h00,1,0, 0,1,2'd3,8'h00,0,16'h0000));
      tv.push_back(mk(0,0,0,8'h00,0,0, 0,1,2'd3,8'h00,0,16'h0000));

      set_in(0, 0, 0, 8'h00, 0, 0);
      do_reset("reset0");
      for (int i = 0; i < tv.size(); i++) begin
         string tg;
         tg = $sformatf("vec%0d", i);
         set_in(tv[i].a, tv[i].p, tv[i].t, tv[i].bm, tv[i].clr, tv[i].rdy);
         step(tg);
         chk({tg, ".t_halt"},   16'(bus.halt),          16'(tv[i].e_halt));
         chk({tg, ".t_thr"},    16'(bus.throttle),      16'(tv[i].e_thr));
         chk({tg, ".t_state"},  16'(bus.state),         16'(tv[i].e_st));
         chk({tg, ".t_sticky"}, 16'(bus.sticky_bitmap), 16'(tv[i].e_stk));
         chk({tg, ".t_valid"},  16'(bus.evt_valid),     16'(tv[i].e_vld));
         chk({tg, ".t_data"},   bus.evt_data,           tv[i].e_dat);
      end

      // Single-cycle alert never qualifies
      do_reset("reset1");
      set_in(1, 5, 3, 8'h08, 0, 1); step("short.a");
      set_in(0, 0, 0, 8'h00, 0, 1); step("short.b");
      step("short.c");
      chk("short.state", 16'(bus.state),     16'd0);
      chk("short.valid", 16'(bus.evt_valid), 16'd0);

      // THROTTLE -> COOLDOWN, cooldown count restarted by an alert at quiet cycle 30
      set_in(1, 4, 1, 8'h02, 0, 1); step("cd.a0");
      step("cd.a1");
      chk("cd.thr_state", 16'(bus.state),    16'd1);
      chk("cd.thr_out",   16'(bus.throttle), 16'd1);
      step("cd.a2");
      set_in(0, 0, 0, 8'h00, 0, 1); step("cd.enter");
      chk("cd.cool_state", 16'(bus.state), 16'd3);
      for (int i = 0; i < 30; i++) step("cd.quiet1");
      set_in(1, 1, 5, 8'h00, 0, 1); step("cd.blip");
      chk("cd.blip_state", 16'(bus.state), 16'd3);
      set_in(0, 0, 0, 8'h00, 0, 1);
      for (int i = 0; i < 63; i++) step("cd.quiet2");
      chk("cd.still_cool", 16'(bus.state),    16'd3);
      chk("cd.still_thr",  16'(bus.throttle), 16'd1);
      step("cd.exit");
      chk("cd.normal",     16'(bus.state),    16'd0);
      chk("cd.thr_off",    16'(bus.throttle), 16'd0);

      // Six episodes into a stalled FIFO: four kept, two dropped, drained in order
      do_reset("reset2");
      for (int e = 0; e < 6; e++) begin
         set_in(1, 1, 3'(e + 1), 8'h01, 0, 0); step("ovf.a"); step("ovf.b");
         set_in(0, 0, 0, 8'h00, 0, 0);          step("ovf.q");
      end
      chk("ovf.dropped", 16'(bus.evt_dropped), 16'd2);
      set_in(0, 0, 0, 8'h00, 0, 1);
      for (int e = 0; e < 4; e++) begin
         exp_rec = {3'(e + 1), 3'd1, 10'(3 * e + 1)};
         chk($sformatf("drain%0d.data", e), bus.evt_data, exp_rec);
         step("drain");
      end
      chk("drain.empty", 16'(bus.evt_valid), 16'd0);

      // Full FIFO with push and pop on the same edge: nothing dropped
      for (int e = 0; e < 4; e++) begin
         set_in(1, 1, 3'(e + 1), 8'h00, 0, 0); step("pp.a"); step("pp.b");
         set_in(0, 0, 0, 8'h00, 0, 0);          step("pp.q");
      end
      set_in(1, 1, 5, 8'h00, 0, 0); step("pp.c0");
      set_in(1, 1, 5, 8'h00, 0, 1); step("pp.c1");
      chk("pp.dropped", 16'(bus.evt_dropped),   16'd2);
      chk("pp.head",    16'(bus.evt_data[15:13]), 16'd2);
      set_in(0, 0, 0, 8'h00, 0, 1);
      for (int i = 0; i < 4; i++) step("pp.drain");

      // Reset in HALT with three queued records
      set_in(0, 0, 0, 8'h00, 0, 0);
      set_in(1, 1, 1, 8'h10, 0, 0); step("mr.a0"); step("mr.a1");
      set_in(0, 0, 0, 8'h00, 0, 0); step("mr.q0");
      set_in(1, 1, 2, 8'h20, 0, 0); step("mr.b0"); step("mr.b1");
      set_in(0, 0, 0, 8'h00, 0, 0); step("mr.q1");
      set_in(1, 7, 7, 8'h80, 0, 0); step("mr.c0"); step("mr.c1");
      chk("mr.halt_state", 16'(bus.state), 16'd2);
      do_reset("midreset");

      // Randomized traffic in quiet / sparse / dense blocks
      for (int blk = 0; blk < 30; blk++) begin
         mode = $urandom_range(0, 2);
         for (int i = 0; i < 100; i++) begin
            logic a;
            logic [2:0] t;
            a = (mode == 0) ? 1'b0 : (mode == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            t = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : bus.alert_type;
            set_in(a, 3'($urandom_range(0, 7)), t, a ? 8'($urandom_range(0, 255)) : 8'h00,
                   $urandom_range(0, 15) == 0, (blk % 4 == 3) ? 1'b0 : ($urandom_range(0, 2) != 0));
            step("rnd");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
